// File: rtl/dff_response_checker.sv
// Golden-model response checker for an enable flop with synchronous clear.
// It compares the DUT's q one cycle after each accepted vector and reports a run verdict.
//
// state | meaning
// IDLE  | after reset, waiting for the first start
// RUN   | accepting vectors and comparing dut_q with the model
// DONE  | verdict is valid and held until the next start
module dff_response_checker #(
    parameter int NUM_VECTORS = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             vec_valid,
    input  logic             vec_sclr,
    input  logic             vec_en,
    input  logic             vec_d,
    input  logic             dut_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [CNT_W-1:0] vec_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] NUM_V    = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    state_t           state;
    logic             exp_q;
    logic             exp_known;
    logic             chk_pending;
    logic [CNT_W-1:0] chk_idx;

    logic accept;
    logic compare;
    logic mismatch;

    assign accept   = (state == RUN) && vec_valid && (vec_idx < NUM_V);
    assign compare  = (state == RUN) && chk_pending;
    // Before the first clear or enable the DUT's flop holds an unknown value.
    assign mismatch = compare && exp_known && (dut_q != exp_q);

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_count == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            err_count      <= '0;
            first_fail_idx <= ALL_ONES;
            vec_idx        <= '0;
            chk_idx        <= '0;
            exp_q          <= 1'b0;
            exp_known      <= 1'b0;
            chk_pending    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= RUN;
                        err_count      <= '0;
                        first_fail_idx <= ALL_ONES;
                        vec_idx        <= '0;
                        exp_known      <= 1'b0;
                        chk_pending    <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        exp_q     <= vec_sclr ? 1'b0 : (vec_en ? vec_d : exp_q);
                        exp_known <= exp_known | vec_sclr | vec_en;
                        chk_idx   <= vec_idx;
                        vec_idx   <= vec_idx + CNT_W'(1);
                    end
                    // A compare and a new acceptance may share an edge.
                    chk_pending <= accept;
                    if (mismatch) begin
                        if (err_count != ALL_ONES)
                            err_count <= err_count + CNT_W'(1);
                        if (first_fail_idx == ALL_ONES)
                            first_fail_idx <= chk_idx;
                    end
                    if (compare && (chk_idx == LAST_IDX))
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dff_response_checker.sv
// Directed bench for dff_response_checker: an ideal (or deliberately faulty) flop
// drives dut_q, and each run's verdict is compared with hand-computed values.
module tb_dff_response_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       vec_valid;
    logic       vec_sclr;
    logic       vec_en;
    logic       vec_d;
    logic       dut_q;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_count;
    logic [7:0] first_fail_idx;
    logic [7:0] vec_idx;

    int checks = 0;
    int errors = 0;

    logic        run_clear = 1'b0;
    logic [15:0] fault_mask = '0;
    logic        bad_prio = 1'b0;
    int          pat = 0;
    logic        ideal_q = 1'b1;
    logic        flip = 1'b0;
    logic [4:0]  tb_idx = '0;

    always #5 clk = ~clk;

    dff_response_checker #(.NUM_VECTORS(16), .CNT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .vec_valid      (vec_valid),
        .vec_sclr       (vec_sclr),
        .vec_en         (vec_en),
        .vec_d          (vec_d),
        .dut_q          (dut_q),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_fail_idx (first_fail_idx),
        .vec_idx        (vec_idx)
    );

    // Stand-in DUT: a flop starting at 1, optionally with enable over clear,
    // and with its output inverted in the cycle after masked vectors.
    always @(posedge clk) begin
        if (run_clear) begin
            tb_idx  <= '0;
            ideal_q <= 1'b1;
            flip    <= 1'b0;
        end else if (vec_valid) begin
            if (bad_prio)
                ideal_q <= vec_en ? vec_d : (vec_sclr ? 1'b0 : ideal_q);
            else
                ideal_q <= vec_sclr ? 1'b0 : (vec_en ? vec_d : ideal_q);
            flip   <= fault_mask[tb_idx[3:0]];
            tb_idx <= tb_idx + 5'd1;
        end else begin
            flip <= 1'b0;
        end
    end

    assign dut_q = ideal_q ^ flip;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] vec_of(input int i, input int p);
        logic [2:0] v;
        v = 3'(i);
        if (p == 1 && i < 2) v = 3'b000;
        if (p == 1 && i == 2) v = 3'b100;
        return v;
    endfunction

    task automatic begin_run(input logic [15:0] mask, input logic bad, input int p);
        @(negedge clk);
        fault_mask = mask;
        bad_prio   = bad;
        pat        = p;
        start      = 1'b1;
        run_clear  = 1'b1;
        vec_valid  = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        run_clear = 1'b0;
    endtask

    task automatic drive_vec(input int i);
        logic [2:0] v;
        v = vec_of(i, pat);
        {vec_sclr, vec_en, vec_d} = v;
        vec_valid = 1'b1;
    endtask

    task automatic run(input string tag, input int gap, input logic [15:0] mask,
                       input logic bad, input int p, input int start_mid,
                       input int exp_err, input int exp_first, input logic exp_pass);
        int cyc;
        int done_cyc;
        begin_run(mask, bad, p);
        cyc = 0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < 16; i++) begin
            drive_vec(i);
            if (start_mid != 0 && i == 8) start = 1'b1;
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (start_mid != 0 && i == 8) chk({tag, "_start_in_run"}, 32'(vec_idx), 32'd9);
            if (p == 1 && i == 3) chk({tag, "_skip_err"}, 32'(err_count), 32'd0);
            if (gap != 0) begin
                vec_valid = 1'b0;
                @(negedge clk);
                cyc++;
            end
        end
        vec_valid = 1'b0;
        done_cyc = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_cyc"}, 32'(done_cyc), (gap != 0) ? 32'd32 : 32'd17);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err_count), 32'(exp_err));
        chk({tag, "_first"}, 32'(first_fail_idx), 32'(exp_first));
        chk({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        chk({tag, "_vec_idx"}, 32'(vec_idx), 32'd16);
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        vec_valid = 1'b0;
        vec_sclr  = 1'b0;
        vec_en    = 1'b0;
        vec_d     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_first", 32'(first_fail_idx), 32'hFF);
        chk("rst_vec_idx", 32'(vec_idx), 32'd0);
        reset = 1'b1;

        // Vectors in IDLE are ignored.
        vec_sclr = 1'b1; vec_en = 1'b1; vec_valid = 1'b1;
        @(negedge clk);
        vec_valid = 1'b0;
        chk("idle_vec_ignored", 32'(vec_idx), 32'd0);

        run("clean", 0, 16'h0000, 1'b0, 0, 0, 0, 'hFF, 1'b1);

        // Vectors after the run completes are ignored.
        drive_vec(3);
        @(negedge clk);
        vec_valid = 1'b0;
        chk("done_vec_ignored", 32'(vec_idx), 32'd16);
        chk("done_held", 32'(done), 32'd1);

        run("skip", 0, 16'h0000, 1'b0, 1, 0, 0, 'hFF, 1'b1);
        run("fault", 0, 16'h0220, 1'b0, 0, 0, 2, 5, 1'b0);
        // Enable-over-clear flop fails at vectors 7, 8, 9 and 15.
        run("prio", 0, 16'h0000, 1'b1, 0, 0, 4, 7, 1'b0);

        // Abort a run with reset after 7 vectors, one of them faulty.
        begin_run(16'h0008, 1'b0, 0);
        for (int i = 0; i < 7; i++) begin
            drive_vec(i);
            @(negedge clk);
        end
        vec_valid = 1'b0;
        chk("mid_err_before", 32'(err_count), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_err", 32'(err_count), 32'd0);
        chk("mid_vec_idx", 32'(vec_idx), 32'd0);
        chk("mid_first", 32'(first_fail_idx), 32'hFF);
        @(negedge clk);
        reset = 1'b1;
        run("after_rst", 0, 16'h0000, 1'b0, 0, 0, 0, 'hFF, 1'b1);

        run("gap1", 1, 16'h0220, 1'b0, 0, 1, 2, 5, 1'b0);
        run("gap2", 1, 16'h0220, 1'b0, 0, 0, 2, 5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
